// File: rtl/cmc_pkg.sv
// Shared types and sizing for the CMC candidate search controller.
//   MAX_CAND : maximum candidates per search
//   IDX_W    : candidate index width
//   DIST_W   : SAD distance width (matches the PE output)
//   LAT      : cycles from an accepted request to a valid distance
//   DIST_MAX : all-ones distance, used as the "no match yet" value
package cmc_pkg;

  localparam int MAX_CAND = 64;
  localparam int IDX_W    = $clog2(MAX_CAND);
  localparam int DIST_W   = 16;
  localparam int LAT      = 2;

  localparam logic [DIST_W-1:0] DIST_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/cmc_search_ctrl_pipe.sv
// In-flight request tracker: a LAT-deep {valid, idx} shift register that
// advances every cycle. The tail lines up with the cycle the PE distance
// for that request is presented.
//   clk_i, clr_i         : clock, synchronous clear
//   push_valid_i/idx_i   : request accepted this cycle and its index
//   tail_valid_o/idx_o   : request whose distance is on dist_in this cycle
//   pending_o            : requests that will still be in flight next cycle
module cmc_inflight_pipe
  import cmc_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             push_valid_i,
  input  logic [IDX_W-1:0] push_idx_i,
  output logic             tail_valid_o,
  output logic [IDX_W-1:0] tail_idx_o,
  output logic             pending_o
);

  logic [LAT-1:0]   valid_q;
  logic [IDX_W-1:0] idx_q [LAT];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < LAT; i++) begin
        valid_q[i] <= 1'b0;
        idx_q[i]   <= '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
      valid_q[0] <= push_valid_i;
      idx_q[0]   <= push_idx_i;
    end
  end

  // Every stage except the tail survives the next shift.
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      pending_o = pending_o | valid_q[i];
    end
  end

  assign tail_valid_o = valid_q[LAT-1];
  assign tail_idx_o   = idx_q[LAT-1];

endmodule

// File: rtl/cmc_search_ctrl.sv
// CMC best-match search controller. Issues candidate indices to the
// reference buffer, tracks them through the SAD PE latency, keeps the
// running minimum and stops early when a distance beats the threshold.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i             : start a search (ignored while busy)
//   num_cand_i, thresh_i: candidate count and early-stop threshold (0 = off)
//   ref_req_o/idx_o     : candidate request to the reference buffer
//   ref_ready_i         : buffer accepts the request this cycle
//   dist_in_i           : PE distance, valid LAT cycles after acceptance
//   busy_o, done_o      : search in progress / one-cycle completion pulse
//   best_idx_o/dist_o   : minimum distance and its index
//   early_hit_o         : search ended by the threshold
module cmc_search_ctrl
  import cmc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [IDX_W:0]    num_cand_i,
  input  logic [DIST_W-1:0] thresh_i,
  output logic              ref_req_o,
  output logic [IDX_W-1:0]  ref_idx_o,
  input  logic              ref_ready_i,
  input  logic [DIST_W-1:0] dist_in_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [IDX_W-1:0]  best_idx_o,
  output logic [DIST_W-1:0] best_dist_o,
  output logic              early_hit_o
);

  state_t            state_q;
  logic [IDX_W:0]    num_q;
  logic [IDX_W:0]    cnt_q;
  logic [IDX_W:0]    cnt_d;
  logic [DIST_W-1:0] thresh_q;
  logic [IDX_W-1:0]  best_idx_q;
  logic [DIST_W-1:0] best_dist_q;
  logic              early_q;
  logic              busy_q;
  logic              done_q;

  logic              accept;
  logic              last_accept;
  logic              tail_valid;
  logic [IDX_W-1:0]  tail_idx;
  logic              pending;
  logic              better;
  logic              hit;

  // The request is withheld while the buffer is not ready, so ref_req
  // and acceptance are the same signal.
  assign accept      = (state_q == ISSUE) && ref_ready_i;
  // Counter is one bit wider than the index so a full MAX_CAND search
  // terminates without wrapping.
  assign cnt_d       = cnt_q + {{IDX_W{1'b0}}, 1'b1};
  assign last_accept = accept && (cnt_d == num_q);
  assign better      = tail_valid && (dist_in_i < best_dist_q);
  assign hit         = tail_valid && (thresh_q != '0) && (dist_in_i < thresh_q);

  cmc_inflight_pipe u_pipe (
    .clk_i        (clk_i),
    .clr_i        (rst_i),
    .push_valid_i (accept),
    .push_idx_i   (cnt_q[IDX_W-1:0]),
    .tail_valid_o (tail_valid),
    .tail_idx_o   (tail_idx),
    .pending_o    (pending)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      num_q       <= '0;
      cnt_q       <= '0;
      thresh_q    <= '0;
      best_idx_q  <= '0;
      best_dist_q <= DIST_MAX;
      early_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Strict compare: a tie keeps the earlier index.
      if (better) begin
        best_dist_q <= dist_in_i;
        best_idx_q  <= tail_idx;
      end
      unique case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (start_i) begin
            num_q       <= num_cand_i;
            thresh_q    <= thresh_i;
            cnt_q       <= '0;
            best_dist_q <= DIST_MAX;
            best_idx_q  <= '0;
            early_q     <= 1'b0;
            if (num_cand_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              busy_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (accept) cnt_q <= cnt_d;
          if (hit) early_q <= 1'b1;
          // A request accepted on the hit cycle is already in the pipe
          // and will still be compared during DRAIN.
          if (hit || last_accept) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!pending) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ref_req_o   = accept;
  assign ref_idx_o   = cnt_q[IDX_W-1:0];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign best_idx_o  = best_idx_q;
  assign best_dist_o = best_dist_q;
  assign early_hit_o = early_q;

endmodule

// File: doc/cmc_search_ctrl.md
Name: cmc_search_ctrl

Overview:
Sequences candidate reference blocks through the CMC codec SAD processing element and selects the best-match candidate. Sits between the reference-block buffer and the SAD PE: issues one candidate index per cycle, tracks in-flight requests over a fixed return latency, and keeps the running minimum distance and its index. Supports early termination when a distance falls below a programmable threshold. Reports the best candidate with a one-cycle done pulse.

Parameters:
MAX_CAND, 64, maximum candidates per search
IDX_W, $clog2(MAX_CAND), candidate index width
DIST_W, 16, SAD distance width (matches PE output)
LAT, 2, cycles from accepted ref_req to valid dist_in (1 buffer read + 1 PE register)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  start search; sampled only in IDLE/DONE
num_cand  in  IDX_W+1  candidates to search, 0..MAX_CAND; latched on start
thresh  in  DIST_W  early-termination threshold; latched on start; 0 disables
ref_req  out  1  request candidate block from reference buffer
ref_idx  out  IDX_W  candidate index for ref_req
ref_ready  in  1  buffer accepts request this cycle (req accepted = ref_req & ref_ready)
dist_in  in  DIST_W  PE distance; valid exactly LAT cycles after an accepted request
busy  out  1  high in ISSUE/DRAIN
done  out  1  one-cycle pulse when result final
best_idx  out  IDX_W  index of minimum distance; held until next start
best_dist  out  DIST_W  minimum distance; held until next start
early_hit  out  1  search ended by threshold; held until next start

Behaviour:
- Reset: state IDLE; ref_req, busy, done, early_hit = 0; best_idx = 0; best_dist = all ones; in-flight pipe cleared. Reset mid-search aborts immediately; late dist_in is ignored.
- States: IDLE -> ISSUE on start (num_cand>0); IDLE -> DONE on start with num_cand=0 (best_dist all ones, best_idx 0, done pulses next cycle); ISSUE -> DRAIN when last index accepted or early stop; DRAIN -> DONE when in-flight pipe empty; DONE -> IDLE after one cycle, or -> ISSUE/DONE if start is high in DONE.
- On start: latch num_cand and thresh, clear issue counter, set best_dist all ones, best_idx 0, early_hit 0.
- ISSUE: ref_req = 1, ref_idx = issue counter; counter increments only on accept; ref_req low and counter held while ref_ready = 0.
- In-flight tracking: LAT-deep shift register of {valid, idx}, advancing every cycle regardless of ref_ready; head loaded with {accept, ref_idx}.
- Compare: when pipe tail valid, if dist_in < best_dist (strict) update best_dist/best_idx. Ties keep the earlier index.
- Early stop: tail valid, thresh != 0 and dist_in < thresh -> early_hit = 1, stop issuing that cycle (ref_req deasserts from the next cycle), go to DRAIN. Requests already in flight are still compared. A request accepted in the same cycle as the hit also completes.
- done asserts in the DONE cycle; best_* and early_hit are stable there and held afterwards.
- start while busy is ignored. No other outputs change in IDLE.
- Latency, no stalls, no early stop: done = N + LAT + 1 cycles after the start cycle.
- Arithmetic: unsigned compare on DIST_W bits; the counter compares against the latched num_cand at IDX_W+1 bits, so num_cand = MAX_CAND needs no wrap.

Decomposition:
- Package cmc_pkg: DIST_W, MAX_CAND localparams, state enum typedef {IDLE, ISSUE, DRAIN, DONE}, DIST_MAX constant (all ones).
- One sub-module cmc_inflight_pipe: LAT-deep {valid, idx} shift register with synchronous clear.
- FSM, counter and min-tracker stay in the top module.

Test Plan:
- num_cand=4, dist sequence 40,25,25,30, thresh=0, ref_ready=1 -> best_idx=1, best_dist=25, early_hit=0, done at cycle 4+LAT+1 after start.
- num_cand=8, dist 100,90,5,80,..., thresh=10 -> early_hit=1, best_idx=2, best_dist=5; in-flight idx 3,4 compared, no req beyond idx 4.
- num_cand=6, ref_ready toggling 1,0,0,1,... -> ref_idx holds during stalls, every index 0..5 is issued exactly once, and the min is correct.
- num_cand=0 -> no ref_req, done one cycle later, best_dist=16'hFFFF, best_idx=0.
- num_cand=64, all dist=7 -> best_idx=0 (tie keeps earliest), 64 requests, counter does not wrap.
- rst asserted in ISSUE at idx 3 -> next cycle IDLE, outputs at reset values; a new start=1 runs a clean search unaffected by stale dist_in.
